// File: rtl/p405s_add_seq_arb_pkg.sv
// Shared types and constants for the two-pass 64-bit adder sequencer.
package p405s_addSeqPkg;

    localparam int ADD_WIDTH = 32;
    localparam int DWIDTH    = 2 * ADD_WIDTH;

    localparam logic REQ_EXE = 1'b0;
    localparam logic REQ_VEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

endpackage

// File: rtl/p405s_add_seq_arb_rrarb2.sv
// Two-input round-robin arbiter; the pointer moves to the loser after every grant.
module p405s_rrArb2 #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o,
    output logic       ptr_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
        gnt_id_o = gnt_o[1];
        ptr_d    = ptr_q;
        if (|gnt_o) begin
            ptr_d = ~gnt_id_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= RR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/p405s_add_seq_arb.sv
// Arbitrates two requesters onto a shared 32-bit adder and runs each 64-bit add
// as a low pass then a carry-chained high pass, returning registered results.
module p405s_add_seq_arb
    import p405s_addSeqPkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                 CB,
    input  logic                 N_reset,
    input  logic [1:0]           reqVal,
    output logic [1:0]           reqRdy,
    input  logic [2*WIDTH-1:0]   reqA0,
    input  logic [2*WIDTH-1:0]   reqB0,
    input  logic [2*WIDTH-1:0]   reqA1,
    input  logic [2*WIDTH-1:0]   reqB1,
    input  logic [1:0]           reqCin,
    input  logic [1:0]           reqSz32,
    output logic [WIDTH-1:0]     adrA,
    output logic [WIDTH-1:0]     adrB,
    output logic                 adrCin,
    input  logic [WIDTH-1:0]     adrSum,
    input  logic                 adrCout,
    input  logic                 adrN_ZP,
    input  logic                 adrN_OP,
    output logic                 rspVal,
    input  logic                 rspRdy,
    output logic                 rspId,
    output logic [2*WIDTH-1:0]   rspSum,
    output logic                 rspCout,
    output logic                 rspZero,
    output logic                 rspOnes
);

    state_e             state_q, state_d;
    logic [1:0]         gnt;
    logic               gnt_id;
    logic               rr_ptr;
    logic               arb_en;

    logic [2*WIDTH-1:0] opA_q, opB_q;
    logic               cin_q, sz32_q, id_q;
    logic [WIDTH-1:0]   sumLo_q, sumHi_q;
    logic               carry_q;
    logic               zLo_q, oLo_q, zHi_q, oHi_q;

    assign arb_en = (state_q == ST_IDLE);

    p405s_rrArb2 #(
        .RR_INIT (RR_INIT)
    ) u_arb (
        .clk_i    (CB),
        .rst_ni   (N_reset),
        .req_i    (reqVal),
        .en_i     (arb_en),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .ptr_o    (rr_ptr)
    );

    always_ff @(posedge CB or negedge N_reset) begin
        if (!N_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|gnt) state_d = ST_LO;
            ST_LO:   state_d = sz32_q ? ST_RSP : ST_HI;
            ST_HI:   state_d = ST_RSP;
            ST_RSP:  if (rspRdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Adder inputs are forced to zero outside the two passes to keep them quiet.
    always_comb begin
        reqRdy = gnt & {2{N_reset}};
        rspVal = (state_q == ST_RSP);
        adrA   = '0;
        adrB   = '0;
        adrCin = 1'b0;
        case (state_q)
            ST_LO: begin
                adrA   = opA_q[WIDTH-1:0];
                adrB   = opB_q[WIDTH-1:0];
                adrCin = cin_q;
            end
            ST_HI: begin
                adrA   = opA_q[2*WIDTH-1:WIDTH];
                adrB   = opB_q[2*WIDTH-1:WIDTH];
                adrCin = carry_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CB or negedge N_reset) begin
        if (!N_reset) begin
            opA_q   <= '0;
            opB_q   <= '0;
            cin_q   <= 1'b0;
            sz32_q  <= 1'b0;
            id_q    <= 1'b0;
            sumLo_q <= '0;
            sumHi_q <= '0;
            carry_q <= 1'b0;
            zLo_q   <= 1'b0;
            oLo_q   <= 1'b0;
            zHi_q   <= 1'b0;
            oHi_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        opA_q  <= (gnt_id == REQ_VEC) ? reqA1 : reqA0;
                        opB_q  <= (gnt_id == REQ_VEC) ? reqB1 : reqB0;
                        cin_q  <= reqCin[gnt_id];
                        sz32_q <= reqSz32[gnt_id];
                        id_q   <= gnt_id;
                    end
                end
                ST_LO: begin
                    sumLo_q <= adrSum;
                    carry_q <= adrCout;
                    zLo_q   <= ~adrN_ZP;
                    oLo_q   <= ~adrN_OP;
                    // A single-word op has a notional all-zero high word.
                    if (sz32_q) begin
                        sumHi_q <= '0;
                        zHi_q   <= 1'b1;
                        oHi_q   <= 1'b1;
                    end
                end
                ST_HI: begin
                    sumHi_q <= adrSum;
                    carry_q <= adrCout;
                    zHi_q   <= ~adrN_ZP;
                    oHi_q   <= ~adrN_OP;
                end
                default: ;
            endcase
        end
    end

    assign rspId   = id_q;
    assign rspSum  = {sumHi_q, sumLo_q};
    assign rspCout = carry_q;
    assign rspZero = zLo_q & zHi_q;
    assign rspOnes = oLo_q & oHi_q;

endmodule

// File: doc/p405s_add_seq_arb.md
Name: p405s_add_seq_arb

Overview:
- Controller for the shared 32-bit adder and its zero/one-predict datapath.
- Arbitrates between two requesters: port 0 is the integer execute unit, port 1 is the vector/AltiVec pipe.
- Sequences each 64-bit operation as two 32-bit passes, low word first, chaining the carry.
- Combines the per-pass predict flags into 64-bit all-zero and all-one result flags and returns results on a valid/ready handshake.

Parameters:
- WIDTH, 32, width of one adder pass; operand and result width is 2*WIDTH.
- RR_INIT, 0, requester that holds round-robin priority after reset.

Ports:
- CB  in  1  core clock, rising edge.
- N_reset  in  1  asynchronous, active-low reset.
- reqVal  in  2  request valid, one bit per requester.
- reqRdy  out  2  request accepted this cycle (one-hot or zero).
- reqA0, reqB0, reqA1, reqB1  in  64 each  operands for requester 0 / 1.
- reqCin  in  2  carry-in per requester.
- reqSz32  in  2  1 = single 32-bit operation (low word only).
- adrA, adrB  out  WIDTH  operands driven to the shared adder and predict.
- adrCin  out  1  carry-in driven to the adder and predict.
- adrSum  in  WIDTH  adder sum, combinational from adrA/adrB/adrCin.
- adrCout  in  1  adder carry-out.
- adrN_ZP, adrN_OP  in  1 each  predict outputs, active-low.
- rspVal  out  1  response valid.
- rspRdy  in  1  response consumer ready.
- rspId  out  1  requester that owns the response.
- rspSum  out  64  result; bits 63:32 are forced to 0 for Sz32.
- rspCout  out  1  final carry-out.
- rspZero, rspOnes  out  1 each  whole result is all-zero / all-one.

Behaviour:
- Reset values: all outputs 0; state IDLE; rrPtr = RR_INIT; capture registers cleared.
- Reset mid-operation aborts the operation; no response is issued.
- States: IDLE, LO, HI, RSP.
- IDLE
  - If any reqVal bit is set: grant one requester, pulse reqRdy for that requester for 1 cycle, latch its operands, cin, sz32 and id; go to LO.
  - Arbitration: if both request, grant rrPtr. Otherwise grant the single requester.
  - After each grant, rrPtr = ~grantedId.
- LO (1 cycle)
  - adrA/adrB = latched low words; adrCin = latched cin.
  - Capture sumLo = adrSum, c = adrCout, zLo = ~adrN_ZP, oLo = ~adrN_OP.
  - If sz32: go to RSP. Otherwise go to HI.
- HI (1 cycle)
  - adrA/adrB = latched high words; adrCin = c captured in LO.
  - Capture sumHi, cout, zHi, oHi; go to RSP.
- RSP
  - rspVal = 1; outputs are registered and held stable until rspRdy.
  - rspZero = zLo & zHi; rspOnes = oLo & oHi.
  - For Sz32: zHi = 1, oHi = 1, rspCout = carry-out from LO.
  - On rspVal & rspRdy: go to IDLE. A new grant is possible the next cycle; there is no bypass.
- adrA/adrB/adrCin are 0 in IDLE and RSP, to hold the adder inputs quiet.
- Latency from grant to rspVal: 2 cycles for Sz32, 3 cycles for 64-bit.
- Throughput: one operation in flight.
- reqVal held while not granted must not be lost. A requester may drop reqVal before grant; it is then not granted.
- Arithmetic is modulo 2^64. Carry out of the low pass feeds the high pass exactly once.
- rspRdy held low stalls indefinitely in RSP; reqRdy stays 0 during the stall.

Decomposition:
- Package p405s_addSeqPkg holds:
  - state enum (IDLE/LO/HI/RSP, 2-bit encoding);
  - localparam DWIDTH = 2*WIDTH;
  - requester id constants (REQ_EXE = 0, REQ_VEC = 1).
- One sub-module, p405s_rrArb2: a 2-input round-robin arbiter with pointer update on grant.

Test Plan:
- 64-bit add, req0 only: A = 0x0000_0000_FFFF_FFFF, B = 1, cin 0 -> rspSum = 0x0000_0001_0000_0000, rspCout 0, rspZero 0, rspVal 3 cycles after grant.
- 64-bit all-ones: A = 0xFFFF_FFFF_FFFF_FFFE, B = 1, cin 0 -> rspSum all-ones, rspOnes 1, rspZero 0; then A = all-ones, B = 1 -> rspSum 0, rspCout 1, rspZero 1.
- Sz32 on req1: A = 0x8000_0000, B = 0x8000_0000 -> rspSum = 0, rspCout 1, rspZero 1, rspId 1, latency 2.
- Simultaneous reqVal = 2'b11 on four back-to-back operations with RR_INIT 0 -> grant order 0,1,0,1; neither request is dropped.
- rspRdy held low 5 cycles -> rspVal and all rsp outputs stable, reqRdy 0; completes on the first cycle rspRdy = 1.
- N_reset asserted during HI -> all outputs 0 immediately; no response after release; next request is served normally.
